seq_pattern_gen: RTL
====================

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 SHALL have parameter PAT_W, default 4, meaning pattern width in bits (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 4, meaning width of the repeat and gap counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port pat_in, input, PAT_W, pattern to transmit, MSB first; sampled on accept.
REQ-006 SHALL have port rep_in, input, CNT_W, repetition count; sampled on accept; 0 is treated as 1.
REQ-007 SHALL have port gap_in, input, CNT_W, idle cycles inserted between repetitions; sampled on accept.
REQ-008 SHALL have port start_valid, input, 1, request to start a transmission.
REQ-009 SHALL have port start_ready, output, 1, high only in IDLE.
REQ-010 SHALL have port abort, input, 1, synchronous cancel of the current transmission.
REQ-011 SHALL have port x_out, output, 1, serial data bit.
REQ-012 SHALL have port bit_valid, output, 1, high while x_out carries a pattern or parity bit.
REQ-013 SHALL have port frame_start, output, 1, high on the first bit of each repetition.
REQ-014 SHALL have port done, output, 1, one-cycle pulse after the final bit of the final repetition.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, SHIFT, GAP and DONE; all outputs SHALL be decoded from registered state only.
REQ-017 Accept SHALL be start_valid && start_ready && !abort at a rising edge; the edge SHALL latch pat_in, rep_in and gap_in and move to SHIFT.
REQ-018 In the first SHIFT cycle after accept, x_out SHALL equal pat_in[PAT_W-1], with bit_valid=1 and frame_start=1.
REQ-019 Each SHIFT cycle SHALL emit one bit, MSB to LSB; a frame SHALL be PAT_W bits, or PAT_W+1 bits with parity (REQ-031).
REQ-020 After the last bit of a frame with repetitions remaining, the FSM SHALL enter GAP for exactly gap cycles if gap>0, otherwise it SHALL start the next frame in the next cycle with no bubble.
REQ-021 In GAP and IDLE, x_out SHALL be 0 and bit_valid SHALL be 0.
REQ-022 After the last bit of the last repetition, the FSM SHALL spend exactly one cycle in DONE (done=1, bit_valid=0), then return to IDLE.
REQ-023 start_valid while busy SHALL be ignored; no input is sampled outside an accept.
REQ-024 abort in any non-IDLE state SHALL return the FSM to IDLE on the next edge, with no done pulse.
REQ-025 abort takes priority over start_valid in IDLE: no accept occurs.
REQ-026 An accept SHALL be possible in the cycle directly after DONE, since start_ready is high in IDLE.
REQ-027 rep_in=0 SHALL behave exactly as rep_in=1; the maximum of 2^CNT_W-1 repetitions SHALL be supported without counter wrap.

Reset
REQ-028 rst_n low SHALL force IDLE asynchronously, with x_out=0, bit_valid=0, frame_start=0, done=0, busy=0 and start_ready=1.
REQ-029 Reset asserted mid-frame SHALL abandon the transmission with no done pulse; the latched pattern and counters SHALL be cleared to 0.
REQ-030 Reset release SHALL be effective from the first rising edge after rst_n goes high.

Configuration
REQ-031 With PATGEN_PARITY_EN defined, each frame SHALL append one even-parity bit (XOR of the latched pattern) after the LSB, with bit_valid=1 and frame_start=0; without the macro, frames SHALL be exactly PAT_W bits and no parity logic SHALL exist.

Structure
REQ-032 Package patgen_pkg SHALL hold the state typedef (IDLE, SHIFT, GAP, DONE) and constant PATGEN_DEFAULT_PAT = 4'b1101.
REQ-033 A sub-module patgen_shifter SHALL implement the load/shift register and bit counter; the FSM and the repeat/gap counters SHALL stay in seq_pattern_gen.

Verification
REQ-034 Single frame: pat=1101, rep=1, gap=0, no parity -> x_out 1,1,0,1 on cycles 1-4 after accept, frame_start only on cycle 1, done on cycle 5, start_ready on cycle 6.
REQ-035 Repeat with gap: pat=1101, rep=2, gap=2 -> 1101, two cycles with bit_valid=0, 1101, done; frame_start exactly twice.
REQ-036 Back-to-back and rep=0: rep=3, gap=0 -> 12 contiguous valid bits; rep=0 -> identical to rep=1.
REQ-037 Abort and reset: abort on the 3rd bit -> IDLE next cycle, no done; rst_n low mid-GAP -> all outputs at reset values immediately, no done.
REQ-038 Busy ignore: start_valid with pat=0000 during an active frame -> current 1101 output unchanged, no second accept.
REQ-039 Parity (PATGEN_PARITY_EN): pat=1101 -> x_out 1,1,0,1,1; pat=1001 -> 1,0,0,1,0; done after the 5th bit.

Source files
------------

// File: rtl/patgen_pkg.sv
// Shared types and constants for the serial pattern generator.
package patgen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] PATGEN_DEFAULT_PAT = 4'b1101;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Start/pattern request and serial output bundle for seq_pattern_gen.
interface seq_pattern_gen_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
);
  logic [PAT_W-1:0] pat_in;
  logic [CNT_W-1:0] rep_in;
  logic [CNT_W-1:0] gap_in;
  logic             start_valid;
  logic             start_ready;
  logic             abort;
  logic             x_out;
  logic             bit_valid;
  logic             frame_start;
  logic             done;
  logic             busy;

  modport master (
    output pat_in, rep_in, gap_in, start_valid, abort,
    input  start_ready, x_out, bit_valid, frame_start, done, busy
  );

  modport slave (
    input  pat_in, rep_in, gap_in, start_valid, abort,
    output start_ready, x_out, bit_valid, frame_start, done, busy
  );
endinterface

// File: rtl/patgen_shifter.sv
// Pattern latch, MSB-first shift register and in-frame bit counter.
// PATGEN_PARITY_EN appends an even-parity bit after the LSB of every frame.
module patgen_shifter #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic             restart_i,
  input  logic             shift_i,
  output logic             bit_o,
  output logic             first_o,
  output logic             last_o
);
`ifdef PATGEN_PARITY_EN
  localparam int FRAME_LEN = PAT_W + 1;
`else
  localparam int FRAME_LEN = PAT_W;
`endif
  localparam int CW = $clog2(FRAME_LEN);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // pat_q keeps the original pattern so later repetitions can reload sh_q
  always_comb begin
    pat_d = pat_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load_i) begin
      pat_d = pat_i;
      sh_d  = pat_i;
      cnt_d = '0;
    end else if (restart_i) begin
      sh_d  = pat_q;
      cnt_d = '0;
    end else if (shift_i) begin
      sh_d  = {sh_q[PAT_W-2:0], 1'b0};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= '0;
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      pat_q <= pat_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef PATGEN_PARITY_EN
  assign bit_o = (cnt_q == CW'(PAT_W)) ? ^pat_q : sh_q[PAT_W-1];
`else
  assign bit_o = sh_q[PAT_W-1];
`endif
  assign first_o = (cnt_q == '0);
  assign last_o  = (cnt_q == CW'(FRAME_LEN - 1));

endmodule

// File: rtl/seq_pattern_gen.sv
// Repeating serial pattern generator: Moore FSM plus repeat/gap counters.
// Optional PATGEN_PARITY_EN (handled in patgen_shifter) adds a parity bit per frame.
module seq_pattern_gen
  import patgen_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  seq_pattern_gen_if.slave bus_if
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;

  logic accept;
  logic sh_restart, sh_shift;
  logic sh_bit, sh_first, sh_last;

  assign accept = bus_if.start_valid && (state_q == IDLE) && !bus_if.abort;

  patgen_shifter #(
    .PAT_W(PAT_W)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept),
    .pat_i    (bus_if.pat_in),
    .restart_i(sh_restart),
    .shift_i  (sh_shift),
    .bit_o    (sh_bit),
    .first_o  (sh_first),
    .last_o   (sh_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // rep_q counts frames still to send including the current one; the shifter
  // is reloaded on the last bit so a zero gap needs no bubble
  always_comb begin
    state_d    = state_q;
    rep_d      = rep_q;
    gap_d      = gap_q;
    gcnt_d     = gcnt_q;
    sh_restart = 1'b0;
    sh_shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          rep_d   = (bus_if.rep_in == '0) ? CNT_W'(1) : bus_if.rep_in;
          gap_d   = bus_if.gap_in;
        end
      end
      SHIFT: begin
        if (bus_if.abort) begin
          state_d = IDLE;
        end else if (sh_last) begin
          if (rep_q == CNT_W'(1)) begin
            state_d = DONE;
          end else begin
            rep_d      = rep_q - 1'b1;
            sh_restart = 1'b1;
            if (gap_q != '0) begin
              state_d = GAP;
              gcnt_d  = gap_q;
            end
          end
        end else begin
          sh_shift = 1'b1;
        end
      end
      GAP: begin
        if (bus_if.abort) begin
          state_d = IDLE;
        end else if (gcnt_q == CNT_W'(1)) begin
          state_d = SHIFT;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_if.x_out       = (state_q == SHIFT) && sh_bit;
    bus_if.bit_valid   = (state_q == SHIFT);
    bus_if.frame_start = (state_q == SHIFT) && sh_first;
    bus_if.done        = (state_q == DONE);
    bus_if.busy        = (state_q != IDLE);
    bus_if.start_ready = (state_q == IDLE);
  end

endmodule
